font_text_ctrl: RTL and testbench
=================================

Name: font_text_ctrl

Overview:
Sequences the 64x8 glyph ROM to render the fixed string "ISA" (glyph codes 1,2,3) as an 8x16 font at a programmable screen position. It turns VGA pixel coordinates into ROM addresses and re-aligns the coordinates to the ROM's one-cycle read latency. It selects the glyph bit and drives registered RGB. A frame-based state machine provides off, steady and blink display modes. It sits between the VGA sync generator and the VGA output pins, and is the only master of the font ROM.

Parameters:
X0, 10'd288, left pixel column of the text box.
Y0, 10'd232, top pixel row of the text box.
NCHAR, 3, characters in the string (text box width = 8*NCHAR pixels).
BLINK_FRAMES, 30, frames per blink half-period (range 1..255).
FG_COLOR, 12'hFFF, foreground RGB444.
BG_COLOR, 12'h000, background RGB444 (inside and outside the box).

Ports:
clk  in  1  system/pixel clock.
reset  in  1  synchronous, active-high.
pixel_x  in  10  current pixel column from sync generator.
pixel_y  in  10  current pixel row.
video_on  in  1  active-video qualifier.
frame_tick  in  1  one-cycle pulse at start of vertical blank.
mode  in  2  00 off, 01 steady, 10 blink, 11 treated as 01.
rom_addr  out  6  address to glyph ROM: {code[1:0], row[3:0]}.
rom_data  in  8  glyph row from ROM, valid 1 cycle after rom_addr; MSB is the leftmost pixel.
rgb  out  12  registered pixel colour.
text_visible  out  1  high while the state machine is in SHOW.

Behaviour:
- Reset: rgb=0, rom_addr=0, text_visible=0, state=OFF, frame counter=0, delay registers=0, mode_q=00.
- Region test (stage 0, combinational): in_box = (pixel_x >= X0) && (pixel_x < X0+8*NCHAR) && (pixel_y >= Y0) && (pixel_y < Y0+16).
  - Compare before subtracting; no 10-bit wrap.
  - col = (pixel_x-X0)>>3; row = (pixel_y-Y0)[3:0].
- rom_addr is combinational from the stage-0 signals: {col+1, row} when in_box, else 6'h00 (blank glyph).
  - The ROM registers the address, so rom_data corresponds to the previous cycle's coordinates.
- Stage 1 registers: bit_sel = pixel_x[2:0] - X0[2:0], plus in_box and video_on delayed one cycle.
- Pixel = rom_data[7-bit_sel] & in_box_d1 & text_visible.
- Output register: rgb = !video_on_d1 ? 0 : (pixel ? fg : BG_COLOR).
- Total latency from pixel_x/pixel_y/video_on to rgb: exactly 2 cycles. The sync generator delays hsync/vsync by 2 externally.
- mode is sampled into mode_q only on frame_tick, so a mode change never tears a frame.
- State machine (advances only on frame_tick):
  - OFF: text_visible=0. If mode_q is 01/11 or 10 -> SHOW, counter=0.
  - SHOW: text_visible=1.
    - mode_q=00 -> OFF.
    - mode_q=10 and counter==BLINK_FRAMES-1 -> HIDE, counter=0.
    - Otherwise counter++; in steady mode counter holds at 0.
  - HIDE: text_visible=0.
    - mode_q=00 -> OFF.
    - mode_q=01/11 -> SHOW immediately.
    - counter==BLINK_FRAMES-1 -> SHOW, counter=0; else counter++.
- The transition uses the mode_q value latched on the same frame_tick, so it takes effect that frame.
- frame_tick while reset is high is ignored.
- Reset mid-frame: outputs go to 0 on the next edge; the pipeline refills within 2 cycles after release.
- frame_tick coinciding with an active-video pixel is legal; rgb continues using the pre-edge text_visible.

Optional Feature:
COLOR_CYCLE_EN
- Defined:
  - A 2-bit palette index advances on every HIDE->SHOW transition.
  - fg = {FG_COLOR, 12'hF00, 12'h0F0, 12'h00F}[index].
  - The index resets to 0 and holds at 0 in steady mode.
- Undefined: fg = FG_COLOR always; no palette register is synthesized.

Decomposition:
- Shared package/header font_pkg.vh holds:
  - GLYPH_W=8, GLYPH_H=16.
  - Glyph codes GLYPH_NULL=0, GLYPH_I=1, GLYPH_S=2, GLYPH_A=3.
  - Mode encodings MODE_OFF/MODE_STEADY/MODE_BLINK.
  - State encodings ST_OFF/ST_SHOW/ST_HIDE.
- One sub-module: blink_fsm, containing the mode_q latch, frame counter, state register and the optional palette index. Outputs text_visible and the colour index.
- Address generation and the pixel pipeline stay in the top level.

Test Plan:
1. Reset, mode=01, one frame_tick, then pixel_x=288, pixel_y=233, video_on=1:
   - rom_addr=6'h11.
   - rgb=12'hFFF two cycles later (ROM row 8'b11111110, bit 7).
2. Steady mode, pixel_x=295, pixel_y=233 -> rom_addr=6'h11; rgb=12'h000 (bit 0 clear).
   - pixel_x=296 -> rom_addr=6'h21 (S).
   - pixel_x=312 -> rom_addr=6'h00.
3. Box edges:
   - pixel_x=287 or pixel_y=248 -> rom_addr=0, rgb=BG.
   - pixel_y=247 -> addr row 4'hF, blank.
   - video_on=0 inside the box -> rgb=0 after 2 cycles.
4. mode=10, BLINK_FRAMES=2:
   - text_visible follows 0,1,1,0,0,1 on successive frame_ticks after the first (OFF->SHOW on tick 1).
5. Change mode from 10 to 00 between ticks -> no output change until the next frame_tick, then text_visible=0 and state OFF.
   - Mid-frame reset pulse -> rgb=0 and text_visible=0 next cycle.
6. COLOR_CYCLE_EN defined, blink mode, BLINK_FRAMES=1:
   - The lit pixel colour sequence on successive SHOW phases is FFF, F00, 0F0, 00F, FFF.

Source files
------------

// File: rtl/font_text_ctrl_pkg.sv
// Shared font geometry, glyph codes, display modes and FSM states for the text overlay.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package font_text_ctrl_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    localparam logic [1:0] GLYPH_NULL = 2'd0;
    localparam logic [1:0] GLYPH_I    = 2'd1;
    localparam logic [1:0] GLYPH_S    = 2'd2;
    localparam logic [1:0] GLYPH_A    = 2'd3;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STEADY = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_HIDE = 2'd2
    } state_t;

    function automatic logic [11:0] palette(input logic [11:0] base, input logic [1:0] idx);
        case (idx)
            2'd0:    return base;
            2'd1:    return 12'hF00;
            2'd2:    return 12'h0F0;
            default: return 12'h00F;
        endcase
    endfunction

endpackage

// File: rtl/font_text_ctrl_blink.sv
// Frame-paced display state machine (off/steady/blink) with optional palette index (COLOR_CYCLE_EN).
// Latency: state and text_visible update on the edge that samples frame_tick.
// Backpressure: none; frame_tick is a free-running pulse.
module blink_fsm
    import font_text_ctrl_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] mode,
    output logic       text_visible
`ifdef COLOR_CYCLE_EN
    ,
    output logic [1:0] color_idx
`endif
);

    localparam logic [7:0] CNT_LAST = 8'(BLINK_FRAMES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] mode_q;
    logic [1:0] mode_eff;
    logic       is_off, is_blink;

    // The mode latched on this tick already governs this tick's transition.
    assign mode_eff = frame_tick ? mode : mode_q;
    assign is_off   = (mode_eff == MODE_OFF);
    assign is_blink = (mode_eff == MODE_BLINK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_OFF;
            cnt    <= 8'd0;
            mode_q <= MODE_OFF;
        end else if (frame_tick) begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                if (!is_off) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = 8'd0;
                end
            end
            ST_SHOW: begin
                if (is_off) begin
                    state_nxt = ST_OFF;
                end else if (is_blink && cnt == CNT_LAST) begin
                    state_nxt = ST_HIDE;
                    cnt_nxt   = 8'd0;
                end else if (is_blink) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    cnt_nxt = 8'd0;
                end
            end
            ST_HIDE: begin
                if (is_off) begin
                    state_nxt = ST_OFF;
                end else if (!is_blink || cnt == CNT_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        text_visible = (state == ST_SHOW);
    end

`ifdef COLOR_CYCLE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            color_idx <= 2'd0;
        end else if (frame_tick) begin
            if (!is_off && !is_blink)
                color_idx <= 2'd0;
            else if (state == ST_HIDE && state_nxt == ST_SHOW)
                color_idx <= color_idx + 2'd1;
        end
    end
`endif

endmodule

// File: rtl/font_text_ctrl.sv
// Renders "ISA" from the glyph ROM at (X0,Y0); palette cycling under COLOR_CYCLE_EN.
// Latency: pixel_x/pixel_y/video_on to rgb is exactly 2 cycles (1 ROM read + 1 output register).
// Backpressure: none; streams one pixel per clock in lockstep with the sync generator.
module font_text_ctrl
    import font_text_ctrl_pkg::*;
#(
    parameter logic [9:0]  X0           = 10'd288,
    parameter logic [9:0]  Y0           = 10'd232,
    parameter int          NCHAR        = 3,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [1:0]  mode,
    output logic [5:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [11:0] rgb,
    output logic        text_visible
);

    // 11-bit bounds so the box end cannot wrap past column 1023.
    localparam logic [10:0] X_END = 11'(X0) + 11'(GLYPH_W * NCHAR);
    localparam logic [10:0] Y_END = 11'(Y0) + 11'(GLYPH_H);

    logic        in_box;
    logic [1:0]  col;
    logic [3:0]  row;
    logic [2:0]  bit_sel_d1;
    logic        in_box_d1;
    logic        video_on_d1;
    logic        pixel;
    logic [11:0] fg;

    assign in_box = ({1'b0, pixel_x} >= {1'b0, X0}) && ({1'b0, pixel_x} < X_END) &&
                    ({1'b0, pixel_y} >= {1'b0, Y0}) && ({1'b0, pixel_y} < Y_END);
    assign col = 2'((pixel_x - X0) >> 3);
    assign row = 4'(pixel_y - Y0);

    always_comb begin
        rom_addr = 6'h00;
        if (!reset && in_box)
            rom_addr = {GLYPH_I + col, row};
    end

    // Stage 1 lines up with the ROM's registered read of last cycle's address.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_sel_d1  <= 3'd0;
            in_box_d1   <= 1'b0;
            video_on_d1 <= 1'b0;
        end else begin
            bit_sel_d1  <= pixel_x[2:0] - X0[2:0];
            in_box_d1   <= in_box;
            video_on_d1 <= video_on;
        end
    end

    assign pixel = rom_data[3'd7 - bit_sel_d1] & in_box_d1 & text_visible;

`ifdef COLOR_CYCLE_EN
    logic [1:0] color_idx;

    blink_fsm #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .mode         (mode),
        .text_visible (text_visible),
        .color_idx    (color_idx)
    );

    assign fg = palette(FG_COLOR, color_idx);
`else
    blink_fsm #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .mode         (mode),
        .text_visible (text_visible)
    );

    assign fg = FG_COLOR;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            rgb <= 12'h000;
        else if (!video_on_d1)
            rgb <= 12'h000;
        else
            rgb <= pixel ? fg : BG_COLOR;
    end

endmodule

// File: tb/tb_font_text_ctrl.sv
// Scoreboard bench for font_text_ctrl with a behavioural registered glyph ROM.
// Expected rom_addr/rgb come from a coordinate model and the bench ROM table.
module tb_font_text_ctrl;

`ifdef COLOR_CYCLE_EN
    localparam int BF = 1;
`else
    localparam int BF = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic [1:0]  mode;
    logic [5:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [11:0] rgb;
    logic        text_visible;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic        tv_m;

    font_text_ctrl #(.BLINK_FRAMES(BF)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .frame_tick   (frame_tick),
        .mode         (mode),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rgb          (rgb),
        .text_visible (text_visible)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [5:0] a);
        if (a[5:4] == 2'd0 || a[3:0] == 4'd0 || a[3:0] == 4'hF) return 8'h00;
        if (a[3:0] == 4'd1) return 8'hFE;
        return 8'h5A ^ {a[3:0], a[5:4], 2'b01};
    endfunction

    always @(posedge clk) rom_data <= glyph(rom_addr);

    function automatic bit box(input int x, input int y);
        return (x >= 288) && (x < 312) && (y >= 232) && (y < 248);
    endfunction

    function automatic logic [5:0] exp_addr(input int x, input int y);
        logic [1:0] code;
        logic [3:0] r;
        if (!box(x, y)) return 6'h00;
        code = 2'(1 + (x - 288) / 8);
        r    = 4'(y - 232);
        return {code, r};
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit von, input bit tv);
        logic [7:0] g;
        if (!von || !box(x, y) || !tv) return 12'h000;
        g = glyph(exp_addr(x, y));
        return g[7 - ((x - 288) % 8)] ? 12'hFFF : 12'h000;
    endfunction

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic set_px(input int x, input int y, input bit v);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_px(290, 233, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        checks++; if (text_visible !== 1'b0) begin errors++; $display("FAIL reset_tv got %b exp 0", text_visible); end
        checks++; if (rom_addr !== 6'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", rom_addr); end
        reset = 1'b0;
        tv_m = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_steady();
        int xs[6] = '{288, 295, 296, 312, 300, 305};
        int ys[6] = '{233, 233, 233, 233, 240, 236};
        logic [11:0] e;
        mode = 2'b01;
        tick();
        tv_m = 1'b1;
        checks++; if (text_visible !== 1'b1) begin errors++; $display("FAIL steady_tv got %b exp 1", text_visible); end
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                set_px(xs[i], ys[i], 1'b1);
                #1;
                checks++;
                if (rom_addr !== exp_addr(xs[i], ys[i])) begin
                    errors++; $display("FAIL steady_addr x=%0d got %h exp %h", xs[i], rom_addr, exp_addr(xs[i], ys[i]));
                end
                exp_q.push_back(exp_rgb(xs[i], ys[i], 1'b1, tv_m));
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                e = exp_q.pop_front();
                checks++; if (rgb !== e) begin errors++; $display("FAIL steady_rgb idx=%0d got %h exp %h", i - 1, rgb, e); end
            end
        end
        mode = 2'b11;
        tick();
        checks++; if (text_visible !== 1'b1) begin errors++; $display("FAIL mode11_tv got %b exp 1", text_visible); end
    endtask

    task automatic test_edges();
        int xs[7] = '{287, 288, 290, 289, 311, 288, 311};
        int ys[7] = '{233, 248, 247, 233, 247, 232, 232};
        bit vs[7] = '{1, 1, 1, 0, 1, 1, 1};
        logic [11:0] e;
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                set_px(xs[i], ys[i], vs[i]);
                #1;
                checks++;
                if (rom_addr !== exp_addr(xs[i], ys[i])) begin
                    errors++; $display("FAIL edge_addr x=%0d y=%0d got %h exp %h", xs[i], ys[i], rom_addr, exp_addr(xs[i], ys[i]));
                end
                exp_q.push_back(exp_rgb(xs[i], ys[i], vs[i], tv_m));
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                e = exp_q.pop_front();
                checks++; if (rgb !== e) begin errors++; $display("FAIL edge_rgb idx=%0d got %h exp %h", i - 1, rgb, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        int x, y;
        for (int i = 0; i <= 80; i++) begin
            if (i < 80) begin
                x = 280 + (i % 40);
                y = (i < 40) ? 234 : 236;
                set_px(x, y, 1'b1);
                #1;
                checks++;
                if (rom_addr !== exp_addr(x, y)) begin
                    errors++; $display("FAIL b2b_addr x=%0d y=%0d got %h exp %h", x, y, rom_addr, exp_addr(x, y));
                end
                exp_q.push_back(exp_rgb(x, y, 1'b1, tv_m));
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                e = exp_q.pop_front();
                checks++; if (rgb !== e) begin errors++; $display("FAIL b2b_rgb idx=%0d got %h exp %h", i - 1, rgb, e); end
            end
        end
    endtask

    task automatic test_blink();
        bit seq[5] = '{1, 1, 0, 0, 1};
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mode = 2'b10;
        set_px(288, 233, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (text_visible !== seq[k]) begin
                errors++; $display("FAIL blink_tv tick=%0d got %b exp %b", k + 1, text_visible, seq[k]);
            end
            if (k == 2) begin
                repeat (2) @(posedge clk);
                #1;
                checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blink_hide_rgb got %h exp 000", rgb); end
            end
        end
        tv_m = 1'b1;
    endtask

    task automatic test_mode_change();
        mode = 2'b00;
        set_px(288, 233, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (text_visible !== 1'b1) begin errors++; $display("FAIL modechg_hold_tv got %b exp 1", text_visible); end
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL modechg_hold_rgb got %h exp fff", rgb); end
        tick();
        checks++; if (text_visible !== 1'b0) begin errors++; $display("FAIL modechg_off_tv got %b exp 0", text_visible); end
        tick();
        checks++; if (text_visible !== 1'b0) begin errors++; $display("FAIL modechg_stay_tv got %b exp 0", text_visible); end
        tv_m = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode = 2'b01;
        set_px(288, 233, 1'b1);
        tick();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL rmid_pre_rgb got %h exp fff", rgb); end
        reset = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rmid_rgb got %h exp 000", rgb); end
        checks++; if (text_visible !== 1'b0) begin errors++; $display("FAIL rmid_tv got %b exp 0", text_visible); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (text_visible !== 1'b0) begin errors++; $display("FAIL rmid_tick_ignored got %b exp 0", text_visible); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rmid_off_rgb got %h exp 000", rgb); end
        tick();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL rmid_refill_rgb got %h exp fff", rgb); end
        tv_m = 1'b1;
    endtask

`ifdef COLOR_CYCLE_EN
    task automatic test_color_cycle();
        logic [11:0] pal[5] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mode = 2'b10;
        set_px(288, 233, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (text_visible !== 1'b1) begin errors++; $display("FAIL color_tv phase=%0d got %b exp 1", k, text_visible); end
            repeat (2) @(posedge clk);
            #1;
            checks++; if (rgb !== pal[k]) begin errors++; $display("FAIL color_rgb phase=%0d got %h exp %h", k, rgb, pal[k]); end
            tick();
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        mode = 2'b00;
        set_px(0, 0, 1'b0);
        tv_m = 1'b0;
        test_reset();
        test_steady();
        test_edges();
        test_back_to_back();
`ifdef COLOR_CYCLE_EN
        test_color_cycle();
`else
        test_blink();
        test_mode_change();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
